// File: rtl/mips_pkg.sv
// mips_pkg: shared arbiter state/grant types and default memory timing constants
package mips_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
  typedef enum logic {GNT_F, GNT_D} arb_gnt_t;
  localparam int DEF_MEM_LAT    = 2;
  localparam int DEF_STARVE_MAX = 4;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates instruction fetch and data load/store onto one single-port memory
// clock/reset_n: clock, async active-low reset
// if_*: fetch request, address, returned instruction, ack pulse
// d_*: data request, write enable, address, write data, load data, ack pulse
// mem_*: memory enable, write enable, address, write data, read data
// stall_f/stall_m: combinational pipeline stalls
module mem_arbiter
  import mips_pkg::*;
#(
  parameter int MEM_LAT    = DEF_MEM_LAT,
  parameter int STARVE_MAX = DEF_STARVE_MAX,
  parameter int AW         = 32,
  parameter int DW         = 32
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall_f,
  output logic          stall_m
);
  localparam int CW = $clog2(MEM_LAT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  if (MEM_LAT < 1 || STARVE_MAX < 1) begin : g_bad_param
    $error("mem_arbiter: MEM_LAT and STARVE_MAX must both be >= 1");
  end
  arb_state_t    state_q;
  arb_gnt_t      gnt_q;
  logic [CW-1:0] cnt_q;
  logic [SW-1:0] starve_q, starve_d;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, if_rdata_q, d_rdata_q;
  logic          we_q, mem_en_q, mem_we_q, if_ack_q, d_ack_q, take_d;
  // data wins unless fetch has waited through STARVE_MAX data grants
  always_comb begin
    take_d   = d_req && (starve_q < SW'(STARVE_MAX) || !if_req);
    starve_d = (take_d && if_req) ? ((starve_q == SW'(STARVE_MAX)) ? starve_q : starve_q + 1'b1) : '0;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      gnt_q      <= GNT_F;
      cnt_q      <= '0;
      starve_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
      case (state_q)
        IDLE: if (take_d || if_req) begin
          gnt_q    <= take_d ? GNT_D : GNT_F;
          addr_q   <= take_d ? d_addr : if_addr;
          we_q     <= take_d & d_we;
          wdata_q  <= take_d ? d_wdata : '0;
          mem_en_q <= 1'b1;
          mem_we_q <= take_d & d_we;
          starve_q <= starve_d;
          state_q  <= ISSUE;
        end
        ISSUE: begin
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
          cnt_q    <= CW'(MEM_LAT - 1);
          state_q  <= WAIT;
        end
        WAIT: if (cnt_q == '0) begin
          // closing edge of the cycle where memory data is valid
          if (gnt_q == GNT_D && !we_q) d_rdata_q <= mem_rdata;
          if (gnt_q == GNT_F) if_rdata_q <= mem_rdata;
          d_ack_q  <= gnt_q == GNT_D;
          if_ack_q <= gnt_q == GNT_F;
          state_q  <= RESP;
        end else cnt_q <= cnt_q - 1'b1;
        RESP: state_q <= IDLE;
      endcase
    end
  end
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign stall_f   = if_req & ~if_ack_q;
  assign stall_m   = d_req & ~d_ack_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter at MEM_LAT 2 (main), 1 and 4
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  logic clock = 1'b0;
  logic reset_n = 1'b1;
  logic if_req [3], if_ack [3], d_req [3], d_we [3], d_ack [3];
  logic mem_en [3], mem_we [3], stall_f [3], stall_m [3];
  logic [31:0] if_addr [3], if_rdata [3], d_addr [3], d_wdata [3], d_rdata [3];
  logic [31:0] mem_addr [3], mem_wdata [3], mem_rdata [3];
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {int g; bit d; logic [31:0] data; int at;} exp_t;
  exp_t sb[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] init_val(input logic [3:0] a);
    return a == 4'h4 ? 32'h8C010001 : a == 4'h1 ? 32'h000000AB :
           a == 4'h8 ? 32'h00001008 : a == 4'h9 ? 32'h00002009 : {28'h5A5A5A5, a};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = g == 0 ? 2 : g == 1 ? 1 : 4;
    logic [31:0] wr_mem [16];
    bit [15:0] wr_vld;
    logic [3:0] pa;
    int cd;
    mem_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(4), .AW(AW), .DW(DW)) dut (
      .clock(clock), .reset_n(reset_n),
      .if_req(if_req[g]), .if_addr(if_addr[g]), .if_rdata(if_rdata[g]), .if_ack(if_ack[g]),
      .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
      .d_rdata(d_rdata[g]), .d_ack(d_ack[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g]), .stall_f(stall_f[g]), .stall_m(stall_m[g])
    );
    always @(posedge clock) begin
      if (mem_en[g] && mem_we[g]) begin
        wr_mem[mem_addr[g][3:0]] <= mem_wdata[g];
        wr_vld[mem_addr[g][3:0]] <= 1'b1;
      end
      if (mem_en[g] && !mem_we[g]) begin
        pa <= mem_addr[g][3:0];
        cd <= LAT;
      end else if (cd > 0) cd <= cd - 1;
    end
    // read data is valid only in cycle ISSUE+LAT; poison otherwise
    assign mem_rdata[g] = cd == 1 ? (wr_vld[pa] ? wr_mem[pa] : init_val(pa)) : 32'hDEADBEEF;
  end

  task automatic wait_ack(input int g, output int at, output bit d, output logic [31:0] data);
    at = -1;
    d = 1'b0;
    data = 'x;
    for (int k = 0; k < 40 && at < 0; k++) begin
      @(negedge clock);
      if (if_ack[g] || d_ack[g]) begin
        at = cyc;
        d = d_ack[g];
        data = d_ack[g] ? d_rdata[g] : if_rdata[g];
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    if_req[0] = 1'b1;
    #1;
    n_chk++; if ({mem_en[0], mem_we[0], mem_addr[0], mem_wdata[0]} !== '0) begin n_fail++; $display("FAIL reset_mem: got %b %b %h %h want zeros", mem_en[0], mem_we[0], mem_addr[0], mem_wdata[0]); end
    n_chk++; if ({if_ack[0], d_ack[0]} !== 2'b00) begin n_fail++; $display("FAIL reset_ack: got %b%b want 00", if_ack[0], d_ack[0]); end
    n_chk++; if ({if_rdata[0], d_rdata[0]} !== '0) begin n_fail++; $display("FAIL reset_rdata: got %h %h want 0 0", if_rdata[0], d_rdata[0]); end
    n_chk++; if (stall_f[0] !== 1'b1) begin n_fail++; $display("FAIL reset_stall_f: got %b want 1", stall_f[0]); end
    n_chk++; if (stall_m[0] !== 1'b0) begin n_fail++; $display("FAIL reset_stall_m: got %b want 0", stall_m[0]); end
    if_req[0] = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    n_chk++; if (mem_en[0] !== 1'b0) begin n_fail++; $display("FAIL idle_no_req: mem_en got %b want 0", mem_en[0]); end
  endtask

  task automatic test_fetch();
    int t0, at;
    bit d, seen;
    logic [31:0] data;
    exp_t e;
    @(negedge clock);
    t0 = cyc;
    if_req[0] = 1'b1;
    if_addr[0] = 32'h4;
    sb.push_back('{0, 1'b0, 32'h8C010001, t0 + 4});
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clock);
      #1;
      n_chk++; if (stall_f[0] !== 1'b1) begin n_fail++; $display("FAIL fetch_stall_f T+%0d: got %b want 1", k, stall_f[0]); end
      n_chk++; if (mem_en[0] !== (k == 1)) begin n_fail++; $display("FAIL fetch_mem_en T+%0d: got %b want %b", k, mem_en[0], k == 1); end
      if (k == 1) begin
        n_chk++; if (mem_addr[0] !== 32'h4 || mem_we[0] !== 1'b0) begin n_fail++; $display("FAIL fetch_issue: addr %h we %b want 4 0", mem_addr[0], mem_we[0]); end
      end
      if (k == 2) begin
        d_req[0] = 1'b1;
        d_we[0] = 1'b0;
        d_addr[0] = 32'h1;
      end
      if (k == 3) d_req[0] = 1'b0;
    end
    wait_ack(0, at, d, data);
    e = sb.pop_front();
    n_chk++; if (at !== e.at) begin n_fail++; $display("FAIL fetch_ack_cycle: got %0d want %0d", at, e.at); end
    n_chk++; if (d !== e.d) begin n_fail++; $display("FAIL fetch_ack_kind: got d=%b want d=%b", d, e.d); end
    n_chk++; if (data !== e.data) begin n_fail++; $display("FAIL fetch_rdata: got %h want %h", data, e.data); end
    n_chk++; if (stall_f[0] !== 1'b0) begin n_fail++; $display("FAIL fetch_stall_at_ack: got %b want 0", stall_f[0]); end
    @(negedge clock);
    if_req[0] = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clock);
      seen |= d_ack[0] | mem_en[0];
    end
    n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL dropped_req_ignored: activity %b want 0", seen); end
  endtask

  task automatic test_both();
    int t0, at;
    bit d;
    logic [31:0] data;
    exp_t e;
    @(negedge clock);
    t0 = cyc;
    if_req[0] = 1'b1;
    if_addr[0] = 32'h4;
    d_req[0] = 1'b1;
    d_we[0] = 1'b0;
    d_addr[0] = 32'h1;
    sb.push_back('{0, 1'b1, 32'h000000AB, t0 + 4});
    sb.push_back('{0, 1'b0, 32'h8C010001, t0 + 9});
    wait_ack(0, at, d, data);
    e = sb.pop_front();
    n_chk++; if (at !== e.at || d !== e.d) begin n_fail++; $display("FAIL both_first: got cyc %0d d=%b want cyc %0d d=%b", at, d, e.at, e.d); end
    n_chk++; if (data !== e.data) begin n_fail++; $display("FAIL both_d_rdata: got %h want %h", data, e.data); end
    @(negedge clock);
    d_req[0] = 1'b0;
    @(negedge clock);
    n_chk++; if (mem_en[0] !== 1'b1 || mem_addr[0] !== 32'h4) begin n_fail++; $display("FAIL both_fetch_issue T+6: en %b addr %h want 1 4", mem_en[0], mem_addr[0]); end
    wait_ack(0, at, d, data);
    e = sb.pop_front();
    n_chk++; if (at !== e.at || d !== e.d) begin n_fail++; $display("FAIL both_second: got cyc %0d d=%b want cyc %0d d=%b", at, d, e.at, e.d); end
    n_chk++; if (data !== e.data) begin n_fail++; $display("FAIL both_if_rdata: got %h want %h", data, e.data); end
    @(negedge clock);
    if_req[0] = 1'b0;
  endtask

  task automatic test_sw();
    int t0, at;
    bit d;
    logic [31:0] data;
    exp_t e;
    @(negedge clock);
    t0 = cyc;
    d_req[0] = 1'b1;
    d_we[0] = 1'b1;
    d_addr[0] = 32'h2;
    d_wdata[0] = 32'h3C00;
    sb.push_back('{0, 1'b1, 32'h000000AB, t0 + 4});
    @(negedge clock);
    n_chk++; if (mem_en[0] !== 1'b1 || mem_we[0] !== 1'b1) begin n_fail++; $display("FAIL sw_issue: en %b we %b want 1 1", mem_en[0], mem_we[0]); end
    n_chk++; if (mem_addr[0] !== 32'h2 || mem_wdata[0] !== 32'h3C00) begin n_fail++; $display("FAIL sw_operands: addr %h wdata %h want 2 3c00", mem_addr[0], mem_wdata[0]); end
    d_req[0] = 1'b0;
    d_we[0] = 1'b0;
    d_addr[0] = 32'hF;
    d_wdata[0] = 32'hFFFF;
    wait_ack(0, at, d, data);
    e = sb.pop_front();
    n_chk++; if (at !== e.at || d !== e.d) begin n_fail++; $display("FAIL sw_ack: got cyc %0d d=%b want cyc %0d d=%b", at, d, e.at, e.d); end
    n_chk++; if (data !== e.data) begin n_fail++; $display("FAIL sw_d_rdata_held: got %h want %h", data, e.data); end
    n_chk++; if (g_dut[0].wr_mem[2] !== 32'h3C00) begin n_fail++; $display("FAIL sw_mem_write: got %h want 3c00", g_dut[0].wr_mem[2]); end
  endtask

  task automatic test_starve();
    int t0, at;
    bit d, dd;
    logic [31:0] data;
    exp_t e;
    @(negedge clock);
    t0 = cyc;
    if_req[0] = 1'b1;
    if_addr[0] = 32'h8;
    d_req[0] = 1'b1;
    d_we[0] = 1'b0;
    d_addr[0] = 32'h9;
    for (int i = 0; i < 10; i++) begin
      dd = (i % 5) != 4;
      sb.push_back('{0, dd, dd ? 32'h00002009 : 32'h00001008, t0 + 4 + 5 * i});
    end
    for (int i = 0; i < 10; i++) begin
      wait_ack(0, at, d, data);
      e = sb.pop_front();
      n_chk++; if (d !== e.d || at !== e.at) begin n_fail++; $display("FAIL starve_grant %0d: got d=%b cyc %0d want d=%b cyc %0d", i, d, at, e.d, e.at); end
      n_chk++; if (data !== e.data) begin n_fail++; $display("FAIL starve_rdata %0d: got %h want %h", i, data, e.data); end
    end
    @(negedge clock);
    if_req[0] = 1'b0;
    d_req[0] = 1'b0;
  endtask

  task automatic test_abort();
    int t0, tr, at;
    bit d;
    logic [31:0] data;
    exp_t e;
    @(negedge clock);
    t0 = cyc;
    d_req[0] = 1'b1;
    d_we[0] = 1'b0;
    d_addr[0] = 32'h1;
    repeat (2) @(negedge clock);
    reset_n = 1'b0;
    #1;
    n_chk++; if ({mem_en[0], mem_we[0], mem_addr[0], mem_wdata[0], if_ack[0], d_ack[0], if_rdata[0], d_rdata[0]} !== '0) begin n_fail++; $display("FAIL abort_outputs_zero: d_rdata %h mem_en %b d_ack %b", d_rdata[0], mem_en[0], d_ack[0]); end
    n_chk++; if (stall_m[0] !== 1'b1) begin n_fail++; $display("FAIL abort_stall_m: got %b want 1", stall_m[0]); end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    tr = cyc;
    n_chk++; if (tr !== t0 + 4) begin n_fail++; $display("FAIL abort_release_cycle: got %0d want %0d", tr, t0 + 4); end
    sb.push_back('{0, 1'b1, 32'h000000AB, tr + 4});
    wait_ack(0, at, d, data);
    e = sb.pop_front();
    n_chk++; if (at !== e.at || d !== e.d) begin n_fail++; $display("FAIL abort_retry_ack: got cyc %0d d=%b want cyc %0d d=%b", at, d, e.at, e.d); end
    n_chk++; if (data !== e.data) begin n_fail++; $display("FAIL abort_retry_rdata: got %h want %h", data, e.data); end
    @(negedge clock);
    d_req[0] = 1'b0;
  endtask

  task automatic test_latency(input int g);
    int t0, at, lat;
    bit d;
    logic [31:0] data;
    exp_t e;
    lat = g == 1 ? 1 : 4;
    @(negedge clock);
    t0 = cyc;
    if_req[g] = 1'b1;
    if_addr[g] = 32'h4;
    sb.push_back('{g, 1'b0, 32'h8C010001, t0 + lat + 2});
    @(negedge clock);
    n_chk++; if (mem_en[g] !== 1'b1 || mem_addr[g] !== 32'h4) begin n_fail++; $display("FAIL lat%0d_issue: en %b addr %h want 1 4", lat, mem_en[g], mem_addr[g]); end
    wait_ack(g, at, d, data);
    e = sb.pop_front();
    n_chk++; if (at !== e.at || d !== e.d) begin n_fail++; $display("FAIL lat%0d_ack: got cyc %0d d=%b want cyc %0d d=%b", lat, at, d, e.at, e.d); end
    n_chk++; if (data !== e.data) begin n_fail++; $display("FAIL lat%0d_rdata: got %h want %h", lat, data, e.data); end
    @(negedge clock);
    if_req[g] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      if_req[i] = 1'b0;
      d_req[i] = 1'b0;
      d_we[i] = 1'b0;
      if_addr[i] = '0;
      d_addr[i] = '0;
      d_wdata[i] = '0;
    end
    #1 reset_n = 1'b0;
    test_reset();
    test_fetch();
    test_both();
    test_sw();
    test_starve();
    test_abort();
    test_latency(1);
    test_latency(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low, with the ports named clock and reset_n.
REQ-002 Parameters SHALL be: MEM_LAT, default 2, memory read latency in cycles (legal range >=1); STARVE_MAX, default 4, maximum consecutive data grants while fetch waits; AW, default 32, address width; DW, default 32, data width.
REQ-003 clock  in  1  rising-edge clock.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 if_req  in  1  fetch request; if_addr  in  AW  fetch address.
REQ-006 if_rdata  out  DW  fetched instruction; if_ack  out  1  one-cycle fetch completion pulse.
REQ-007 d_req  in  1  data request; d_we  in  1  1=sw, 0=lw; d_addr  in  AW; d_wdata  in  DW.
REQ-008 d_rdata  out  DW  load data; d_ack  out  1  one-cycle data completion pulse.
REQ-009 mem_en  out  1; mem_we  out  1; mem_addr  out  AW; mem_wdata  out  DW; mem_rdata  in  DW  (single-port unified memory).
REQ-010 stall_f  out  1  fetch stage stall; stall_m  out  1  MEM stage stall.

Function
REQ-011 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP; a transaction SHALL occupy IDLE(T), ISSUE(T+1), WAIT(T+2..T+1+MEM_LAT) and RESP(T+2+MEM_LAT), then return to IDLE.
REQ-012 In IDLE with no request pending, the FSM SHALL remain in IDLE.
REQ-013 In IDLE the grant SHALL be registered as follows: data if d_req and (starve_cnt<STARVE_MAX or !if_req); otherwise fetch if if_req.
REQ-014 The address, we and wdata of the granted requester SHALL be latched at the IDLE->ISSUE edge; later changes to requester inputs SHALL have no effect on the transaction.
REQ-015 mem_en SHALL be 1 for exactly the ISSUE cycle, with mem_addr/mem_we/mem_wdata driven from the latched values; mem_we SHALL be 0 for fetch.
REQ-016 mem_rdata SHALL be taken as valid in cycle ISSUE+MEM_LAT (the last WAIT cycle) and captured on that cycle's closing edge.
REQ-017 In RESP the grantee's ack SHALL be 1 for one cycle, with if_rdata/d_rdata presenting the captured data.
REQ-018 The *_rdata registers SHALL hold their value otherwise; d_rdata SHALL be unchanged on a write.
REQ-019 Request-to-ack latency SHALL be MEM_LAT+2 cycles, and one transaction SHALL complete per MEM_LAT+3 cycles.
REQ-020 Requesters SHALL hold req and operands until ack and update them in the cycle after ack; the IDLE cycle following RESP SHALL re-arbitrate on the current inputs.
REQ-021 A req that drops before grant SHALL be ignored; a req that drops after grant SHALL still complete, and its ack SHALL still pulse.
REQ-022 starve_cnt SHALL increment (saturating at STARVE_MAX) on each data grant made while if_req=1, and clear on each fetch grant or on a data grant made with if_req=0.
REQ-023 stall_f SHALL equal if_req & !if_ack, and stall_m SHALL equal d_req & !d_ack; both SHALL be combinational.
REQ-024 mem_rdata SHALL be ignored outside the capture cycle.

Reset
REQ-025 On reset_n=0: state=IDLE, starve_cnt=0, mem_en=mem_we=0, mem_addr=mem_wdata=0, acks=0, if_rdata=d_rdata=0, latched operands=0.
REQ-026 Reset asserted mid-transaction SHALL abort the transaction: no ack is produced, and the requester re-arbitrates from IDLE after release.
REQ-027 Reset release SHALL take effect on the first rising edge with reset_n=1; arbitration SHALL begin in that cycle.

Structure
REQ-028 Shared package mips_pkg SHALL hold the arb_state_t enum (IDLE/ISSUE/WAIT/RESP), the grant encoding (GNT_F, GNT_D) and default MEM_LAT/STARVE_MAX constants.
REQ-029 The block SHALL be a single module with no sub-module; the WAIT down-counter SHALL be $clog2(MEM_LAT+1) bits wide.
REQ-030 An elaboration check SHALL reject MEM_LAT<1 or STARVE_MAX<1.

Verification
REQ-031 Fetch only, MEM_LAT=2: if_req, if_addr=0x4, memory returns 0x8C010001 -> mem_en at T+1 with mem_addr=0x4; if_ack at T+4 with if_rdata=0x8C010001; stall_f high T..T+3.
REQ-032 Simultaneous if_req and d_req (lw, d_addr=0x1, mem 0x000000AB) -> data served first, d_ack at T+4 with d_rdata=0xAB; fetch mem_en at T+6; if_ack at T+9.
REQ-033 sw d_addr=0x2, d_wdata=0x3C00 -> mem_en=mem_we=1 at T+1 with mem_wdata=0x3C00; d_ack at T+4; d_rdata unchanged.
REQ-034 d_req and if_req held continuously with STARVE_MAX=4 -> grant order D,D,D,D,F,D,D,D,D,F; starve_cnt never exceeds 4.
REQ-035 reset_n pulsed low during WAIT of a lw -> no d_ack and all outputs zero; after release with d_req held -> a fresh transaction and d_ack MEM_LAT+2 cycles after the first IDLE.
REQ-036 Repeat REQ-031 with MEM_LAT=1 and MEM_LAT=4 -> if_ack at T+3 and T+6 respectively.
